// File: rtl/gmii_to_pkt_134b_pkg.sv
// Shared definitions for the GMII <-> 134b packet-word converters.
// Tag encodings, framing bytes and 134b word field positions.
package gmii_to_pkt_134b_pkg;

  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int PKT_W    = 134;
  localparam int TAG_HI   = 133;
  localparam int TAG_LO   = 132;
  localparam int VCNT_HI  = 131;
  localparam int VCNT_LO  = 128;
  localparam int DATA_HI  = 127;
  localparam int DATA_LO  = 0;
  localparam int LANES    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } rx_state_e;

  function automatic logic [PKT_W-1:0] pack_word(input logic [1:0]   tag,
                                                 input logic [3:0]   vcnt,
                                                 input logic [127:0] data);
    return {tag, vcnt, data};
  endfunction

endpackage

// File: rtl/gmii_to_pkt_134b.sv
// GMII receive byte stream to 134b packet words plus per-frame length metadata.
// Strips preamble/SFD, packs 16 bytes per word, drops runts and truncates at MAX_LEN.
module gmii_to_pkt_134b
  import gmii_to_pkt_134b_pkg::*;
#(
  parameter int MAX_LEN = 1536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_data,
  input  logic             gmii_data_valid,
  input  logic             pkt_fifo_afull,
  output logic             pkt_data_wr,
  output logic [PKT_W-1:0] pkt_data,
  output logic             meta_wr,
  output logic [15:0]      meta_data,
  output logic [31:0]      cnt_pkt,
  output logic [31:0]      cnt_drop
);

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [11:0] LAST_IDX  = 12'(MAX_LEN - 1);
  localparam logic [11:0] RUNT_LEN  = 12'd16;

  rx_state_e    state, state_next;
  logic [11:0]  byte_cnt;
  logic [3:0]   lane;
  logic [127:0] asm_data;
  logic [127:0] asm_ins;
  logic [127:0] hold_data;
  logic         hold_full;
  logic         hold_head;
  logic         tail_pend;
  logic [127:0] tail_data;

  logic drop_inc;
  logic start_frame;
  logic take_byte;
  logic end_frame;
  logic truncate;

  assign lane     = byte_cnt[3:0];
  assign truncate = take_byte && (byte_cnt == LAST_IDX);

  // Assembly word with the current byte dropped into its lane; lane 0 is the MSB byte.
  always_comb begin
    asm_ins = asm_data;
    asm_ins[{~lane, 3'b000} +: 8] = gmii_data;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    drop_inc    = 1'b0;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gmii_data_valid) begin
          if (gmii_data == PREAMBLE_BYTE) begin
            state_next = S_PREAMBLE;
          end else begin
            state_next = S_DROP;
            drop_inc   = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!gmii_data_valid) begin
          state_next = S_IDLE;
        end else if (gmii_data == SFD_BYTE && !pkt_fifo_afull) begin
          state_next  = S_DATA;
          start_frame = 1'b1;
        end else if (gmii_data != PREAMBLE_BYTE) begin
          state_next = S_DROP;
          drop_inc   = 1'b1;
        end
      end
      S_DATA: begin
        if (!gmii_data_valid) begin
          state_next = S_IDLE;
          end_frame  = 1'b1;
          drop_inc   = (byte_cnt <= RUNT_LEN);
        end else begin
          take_byte = 1'b1;
          if (byte_cnt == LAST_IDX) state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (!gmii_data_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: reset is asynchronous and active-low; every flop, datapath included, is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; later ones override the defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_data_wr <= 1'b0;
      pkt_data    <= '0;
      meta_wr     <= 1'b0;
      meta_data   <= '0;
      cnt_pkt     <= '0;
      cnt_drop    <= '0;
      byte_cnt    <= '0;
      asm_data    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      hold_head   <= 1'b0;
      tail_pend   <= 1'b0;
      tail_data   <= '0;
    end else begin
      pkt_data_wr <= 1'b0;
      meta_wr     <= 1'b0;
      tail_pend   <= 1'b0;

      if (drop_inc) cnt_drop <= cnt_drop + 32'd1;

      // Deferred truncation tail: the held word took this slot's predecessor.
      if (tail_pend) begin
        pkt_data_wr <= 1'b1;
        pkt_data    <= pack_word(TAG_TAIL, 4'h0, tail_data);
        meta_wr     <= 1'b1;
        meta_data   <= {1'b1, 3'b000, MAX_LEN_W};
        cnt_pkt     <= cnt_pkt + 32'd1;
      end

      if (start_frame) begin
        byte_cnt  <= '0;
        asm_data  <= '0;
        hold_full <= 1'b0;
        hold_head <= 1'b1;
      end

      if (take_byte) begin
        byte_cnt <= byte_cnt + 12'd1;
        // First byte of a new word proves the held word is not the tail.
        if (lane == 4'h0 && hold_full) begin
          pkt_data_wr <= 1'b1;
          pkt_data    <= pack_word(hold_head ? TAG_HEAD : TAG_BODY, 4'hF, hold_data);
          hold_full   <= 1'b0;
          hold_head   <= 1'b0;
        end
        if (truncate) begin
          if (lane == 4'h0 && hold_full) begin
            tail_pend <= 1'b1;
            tail_data <= asm_ins;
          end else begin
            pkt_data_wr <= 1'b1;
            pkt_data    <= pack_word(TAG_TAIL, lane, asm_ins);
            meta_wr     <= 1'b1;
            meta_data   <= {1'b1, 3'b000, MAX_LEN_W};
            cnt_pkt     <= cnt_pkt + 32'd1;
          end
        end else if (lane == 4'hF) begin
          hold_data <= asm_ins;
          hold_full <= 1'b1;
          asm_data  <= '0;
        end else begin
          asm_data <= asm_ins;
        end
      end

      if (end_frame && byte_cnt > RUNT_LEN) begin
        pkt_data_wr <= 1'b1;
        if (lane == 4'h0) begin
          pkt_data <= pack_word(TAG_TAIL, 4'hF, hold_data);
        end else begin
          pkt_data <= pack_word(TAG_TAIL, lane - 4'h1, asm_data);
        end
        meta_wr   <= 1'b1;
        meta_data <= {1'b0, 3'b000, byte_cnt};
        cnt_pkt   <= cnt_pkt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_to_pkt_134b.sv
// Directed bench for gmii_to_pkt_134b: three instances (MAX_LEN 1536, 64, 17)
// driven from a vector table plus hand-written back-to-back and reset sequences.
module tb_gmii_to_pkt_134b;

  typedef struct {
    int          inst;
    int          len;
    int          seed;
    bit          bad_pre;
    bit          afull;
    int          exp_words;
    int          exp_meta_n;
    logic [15:0] exp_meta;
    logic [31:0] exp_pkt;
    logic [31:0] exp_drop;
  } vec_t;

  typedef struct {
    int           inst;
    logic [133:0] w;
  } wcap_t;

  typedef struct {
    int          inst;
    logic [15:0] m;
  } mcap_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   gd      [3];
  logic         gv      [3];
  logic         af      [3];
  logic         pkt_wr  [3];
  logic [133:0] pkt_d   [3];
  logic         meta_wr [3];
  logic [15:0]  meta_d  [3];
  logic [31:0]  cpkt    [3];
  logic [31:0]  cdrop   [3];

  wcap_t wq[$];
  mcap_t mq[$];
  wcap_t wc_tmp;
  mcap_t mc_tmp;
  logic  prev_wr [3];
  int    n_checks = 0;
  int    n_err    = 0;
  int    bad_b2b  = 0;
  vec_t  vecs [11];

  always #5 clk = ~clk;

  gmii_to_pkt_134b u_dut0 (
    .clk(clk), .rst_n(rst_n), .gmii_data(gd[0]), .gmii_data_valid(gv[0]),
    .pkt_fifo_afull(af[0]), .pkt_data_wr(pkt_wr[0]), .pkt_data(pkt_d[0]),
    .meta_wr(meta_wr[0]), .meta_data(meta_d[0]), .cnt_pkt(cpkt[0]), .cnt_drop(cdrop[0])
  );

  gmii_to_pkt_134b #(.MAX_LEN(64)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .gmii_data(gd[1]), .gmii_data_valid(gv[1]),
    .pkt_fifo_afull(af[1]), .pkt_data_wr(pkt_wr[1]), .pkt_data(pkt_d[1]),
    .meta_wr(meta_wr[1]), .meta_data(meta_d[1]), .cnt_pkt(cpkt[1]), .cnt_drop(cdrop[1])
  );

  gmii_to_pkt_134b #(.MAX_LEN(17)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .gmii_data(gd[2]), .gmii_data_valid(gv[2]),
    .pkt_fifo_afull(af[2]), .pkt_data_wr(pkt_wr[2]), .pkt_data(pkt_d[2]),
    .meta_wr(meta_wr[2]), .meta_data(meta_d[2]), .cnt_pkt(cpkt[2]), .cnt_drop(cdrop[2])
  );

  // Capture writes on the falling edge, away from the registering edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pkt_wr[k] === 1'b1) begin
        wc_tmp.inst = k;
        wc_tmp.w    = pkt_d[k];
        wq.push_back(wc_tmp);
        if (prev_wr[k] === 1'b1 && pkt_d[k][133:132] != 2'b10) bad_b2b++;
      end
      if (meta_wr[k] === 1'b1) begin
        mc_tmp.inst = k;
        mc_tmp.m    = meta_d[k];
        mq.push_back(mc_tmp);
      end
      prev_wr[k] = pkt_wr[k];
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input logic v, input logic [7:0] d, input logic a);
    @(posedge clk);
    #1;
    gv[inst] = v;
    gd[inst] = d;
    af[inst] = a;
  endtask

  task automatic send_frame(input int inst, input int len, input int seed,
                            input bit bad_pre, input bit afull);
    for (int i = 0; i < 7; i++) drive(inst, 1'b1, (bad_pre && i == 2) ? 8'h5D : 8'h55, 1'b0);
    drive(inst, 1'b1, 8'hD5, afull);
    for (int i = 0; i < len; i++) drive(inst, 1'b1, 8'(seed + i), 1'b0);
    drive(inst, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #2;
  endtask

  // Expected word w of a stored frame whose byte i is (seed + i).
  function automatic logic [133:0] exp_word(input int seed, input int stored, input int w);
    int           n;
    int           nb;
    logic [1:0]   tag;
    logic [127:0] d;
    n  = (stored + 15) / 16;
    nb = stored - 16 * w;
    if (nb > 16) nb = 16;
    if (w == n - 1)  tag = 2'b10;
    else if (w == 0) tag = 2'b01;
    else             tag = 2'b00;
    d = '0;
    for (int j = 0; j < nb; j++) d[127 - 8*j -: 8] = 8'(seed + 16*w + j);
    return {tag, 4'(nb - 1), d};
  endfunction

  task automatic check_words(input string name, input int inst, input int seed,
                             input int stored, input int first);
    int n;
    n = (stored + 15) / 16;
    for (int w = 0; w < n; w++) begin
      if (first + w < wq.size()) begin
        check($sformatf("%s word%0d inst", name, w), wq[first + w].inst, inst);
        check($sformatf("%s word%0d", name, w), wq[first + w].w, exp_word(seed, stored, w));
      end
    end
  endtask

  initial begin
    vec_t v;
    //           inst len  seed   bad afull words metas meta     pkt drop
    vecs[0]  = '{0,   64,  'h00,  0,  0,    4,    1,    16'h0040, 1,  0};
    vecs[1]  = '{0,   65,  'h00,  0,  0,    5,    1,    16'h0041, 2,  0};
    vecs[2]  = '{0,   16,  'h10,  0,  0,    0,    0,    16'h0000, 2,  1};
    vecs[3]  = '{0,   64,  'h20,  0,  1,    0,    0,    16'h0000, 2,  2};
    vecs[4]  = '{0,   64,  'h40,  0,  0,    4,    1,    16'h0040, 3,  2};
    vecs[5]  = '{0,   100, 'h00,  1,  0,    0,    0,    16'h0000, 3,  3};
    vecs[6]  = '{0,   100, 'h80,  0,  0,    7,    1,    16'h0064, 4,  3};
    vecs[7]  = '{0,   17,  'h33,  0,  0,    2,    1,    16'h0011, 5,  3};
    vecs[8]  = '{1,   100, 'h00,  0,  0,    4,    1,    16'h8040, 1,  0};
    vecs[9]  = '{1,   40,  'h60,  0,  0,    3,    1,    16'h0028, 2,  0};
    vecs[10] = '{2,   30,  'h00,  0,  0,    2,    1,    16'h8011, 1,  0};

    for (int k = 0; k < 3; k++) begin
      gd[k] = 8'h00;
      gv[k] = 1'b0;
      af[k] = 1'b0;
      prev_wr[k] = 1'b0;
    end

    #1 rst_n = 1'b0;
    #10;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset strobes/data inst%0d", k),
            {pkt_wr[k], pkt_d[k], meta_wr[k], meta_d[k]}, '0);
      check($sformatf("reset cnt_pkt inst%0d", k), cpkt[k], 32'd0);
      check($sformatf("reset cnt_drop inst%0d", k), cdrop[k], 32'd0);
    end
    #12 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      wq.delete();
      mq.delete();
      send_frame(v.inst, v.len, v.seed, v.bad_pre, v.afull);
      settle();
      check($sformatf("v%0d word count", i), wq.size(), v.exp_words);
      check_words($sformatf("v%0d", i), v.inst, v.seed,
                  (v.exp_words > 0) ? int'(v.exp_meta[11:0]) : 0, 0);
      check($sformatf("v%0d meta count", i), mq.size(), v.exp_meta_n);
      if (mq.size() > 0 && v.exp_meta_n > 0)
        check($sformatf("v%0d meta", i), mq[0].m, v.exp_meta);
      check($sformatf("v%0d cnt_pkt", i), cpkt[v.inst], v.exp_pkt);
      check($sformatf("v%0d cnt_drop", i), cdrop[v.inst], v.exp_drop);
      if (i == 0 && wq.size() > 0)
        check("v0 word0 data", wq[0].w[127:0], 128'h000102030405060708090A0B0C0D0E0F);
      if (i == 6 && wq.size() > 6)
        check("v6 last tag/valid", wq[6].w[133:128], 6'b10_0011);
    end

    // Truncated frame followed by a normal one with a single idle cycle between.
    wq.delete();
    mq.delete();
    send_frame(1, 80, 'h11, 1'b0, 1'b0);
    send_frame(1, 33, 'h22, 1'b0, 1'b0);
    settle();
    check("b2b trunc word count", wq.size(), 7);
    check_words("b2b trunc a", 1, 'h11, 64, 0);
    check_words("b2b trunc b", 1, 'h22, 33, 4);
    check("b2b trunc meta count", mq.size(), 2);
    if (mq.size() == 2) begin
      check("b2b trunc meta a", mq[0].m, 16'h8040);
      check("b2b trunc meta b", mq[1].m, 16'h0021);
    end
    check("b2b trunc cnt_pkt", cpkt[1], 32'd4);
    check("b2b trunc cnt_drop", cdrop[1], 32'd0);

    // Partial tail flush overlaps the next frame's preamble.
    wq.delete();
    mq.delete();
    send_frame(0, 33, 'h44, 1'b0, 1'b0);
    send_frame(0, 20, 'h55, 1'b0, 1'b0);
    settle();
    check("b2b flush word count", wq.size(), 5);
    check_words("b2b flush a", 0, 'h44, 33, 0);
    check_words("b2b flush b", 0, 'h55, 20, 3);
    check("b2b flush meta count", mq.size(), 2);
    if (mq.size() == 2) begin
      check("b2b flush meta a", mq[0].m, 16'h0021);
      check("b2b flush meta b", mq[1].m, 16'h0014);
    end
    check("b2b flush cnt_pkt", cpkt[0], 32'd7);
    check("b2b flush cnt_drop", cdrop[0], 32'd3);

    // Reset in the middle of a frame: head already out, no tail may follow.
    wq.delete();
    mq.delete();
    for (int i = 0; i < 7; i++) drive(0, 1'b1, 8'h55, 1'b0);
    drive(0, 1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(0, 1'b1, 8'(8'h70 + i), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    gv[0] = 1'b0;
    gd[0] = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    check("mid-reset word count", wq.size(), 1);
    if (wq.size() > 0) check("mid-reset head tag", wq[0].w[133:132], 2'b01);
    check("mid-reset meta count", mq.size(), 0);
    check("mid-reset cnt_pkt", cpkt[0], 32'd0);
    check("mid-reset cnt_drop", cdrop[0], 32'd0);
    check("mid-reset pkt_data_wr", pkt_wr[0], 1'b0);
    rst_n = 1'b1;
    wq.delete();
    mq.delete();
    send_frame(0, 64, 'h00, 1'b0, 1'b0);
    settle();
    check("post-reset word count", wq.size(), 4);
    check_words("post-reset", 0, 'h00, 64, 0);
    check("post-reset meta count", mq.size(), 1);
    if (mq.size() > 0) check("post-reset meta", mq[0].m, 16'h0040);
    check("post-reset cnt_pkt", cpkt[0], 32'd1);

    check("consecutive non-tail writes", bad_b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
